// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute sequencer for the Simple CPU: owns PC and IR, drives the ROM
// address and issues one-cycle accumulator strobes during EXECUTE.
module cpu_sequencer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run,
  input  logic [DATA_WIDTH-1:0] instruction,
  input  logic                  zero,
  output logic [ADDR_WIDTH-1:0] address,
  output logic                  acc_inc,
  output logic                  acc_load,
  output logic [DATA_WIDTH-1:0] imm,
  output logic [1:0]            state,
  output logic                  instr_done
);

  localparam int unsigned OpW = DATA_WIDTH - ADDR_WIDTH;

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StFetch   = 2'b01,
    StDecode  = 2'b10,
    StExecute = 2'b11
  } state_e;

  localparam logic [1:0] OpLdi = 2'b00;
  localparam logic [1:0] OpJz  = 2'b01;
  localparam logic [1:0] OpJmp = 2'b10;
  localparam logic [1:0] OpInc = 2'b11;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] ir_q, ir_d;
  // Control decoded in DECODE, consumed in EXECUTE.
  logic                  inc_q, inc_d;
  logic                  load_q, load_d;
  logic                  jmp_q, jmp_d;
  logic                  jz_q, jz_d;
  logic                  done_q, done_d;
  logic [1:0]            opcode;

  assign opcode = ir_q[DATA_WIDTH-1 -: 2];

  // State, PC, IR and strobe registers; reset aborts any in-flight instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pc_q    <= '0;
      ir_q    <= '0;
      inc_q   <= 1'b0;
      load_q  <= 1'b0;
      jmp_q   <= 1'b0;
      jz_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      inc_q   <= inc_d;
      load_q  <= load_d;
      jmp_q   <= jmp_d;
      jz_q    <= jz_d;
      done_q  <= done_d;
    end
  end

  // Next-state, PC update and decode; strobe flops are only set when leaving DECODE.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    inc_d   = 1'b0;
    load_d  = 1'b0;
    jmp_d   = 1'b0;
    jz_d    = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (run) state_d = StFetch;
      end
      StFetch: begin
        ir_d    = instruction;
        pc_d    = pc_q + ADDR_WIDTH'(1);
        state_d = StDecode;
      end
      StDecode: begin
        inc_d   = (opcode == OpInc);
        load_d  = (opcode == OpLdi);
        jmp_d   = (opcode == OpJmp);
        jz_d    = (opcode == OpJz);
        done_d  = 1'b1;
        state_d = StExecute;
      end
      StExecute: begin
        // Jump target overrides the PC+1 taken in FETCH.
        if (jmp_q || (jz_q && zero)) pc_d = ir_q[ADDR_WIDTH-1:0];
        state_d = run ? StFetch : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign address    = pc_q;
  assign acc_inc    = inc_q;
  assign acc_load   = load_q;
  assign instr_done = done_q;
  assign state      = state_q;
  assign imm        = {{OpW{1'b0}}, ir_q[ADDR_WIDTH-1:0]};

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: per-cycle expectations are queued when a program
// is started and popped/compared once per clock at the falling edge.
module tb_cpu_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic [7:0] instruction;
  logic       zero;
  logic [5:0] address;
  logic       acc_inc;
  logic       acc_load;
  logic [7:0] imm;
  logic [1:0] state;
  logic       instr_done;

  logic [7:0] rom [64];

  int n_cmp = 0;
  int n_err = 0;
  int inc_cnt = 0;

  typedef struct packed {
    logic [1:0] st;
    logic [5:0] addr;
    logic       inc;
    logic       load;
    logic       imm_chk;
    logic [7:0] imm;
    logic       done;
  } exp_t;

  exp_t exp_q[$];

  cpu_sequencer #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(6)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .instruction(instruction),
    .zero       (zero),
    .address    (address),
    .acc_inc    (acc_inc),
    .acc_load   (acc_load),
    .imm        (imm),
    .state      (state),
    .instr_done (instr_done)
  );

  always #5 clk = ~clk;

  assign instruction = rom[address];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push(input logic [1:0] st, input logic [5:0] addr, input logic inc,
                      input logic load, input logic imm_chk, input logic [7:0] immv,
                      input logic done);
    exp_t e;
    e.st = st; e.addr = addr; e.inc = inc; e.load = load;
    e.imm_chk = imm_chk; e.imm = immv; e.done = done;
    exp_q.push_back(e);
  endtask

  // One instruction at address a: FETCH, DECODE, EXECUTE.
  task automatic push_instr(input logic [5:0] a, input logic inc, input logic load,
                            input logic [7:0] immv);
    logic [5:0] a1;
    a1 = a + 6'd1;
    push(2'b01, a, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    push(2'b10, a1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    push(2'b11, a1, inc, load, load, immv, 1'b1);
  endtask

  // Compare the current cycle against the scoreboard head, then advance one clock.
  task automatic step();
    exp_t e;
    if (exp_q.size() == 0) begin
      check_eq("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check_eq("state", 32'(state), 32'(e.st));
      check_eq("address", 32'(address), 32'(e.addr));
      check_eq("acc_inc", 32'(acc_inc), 32'(e.inc));
      check_eq("acc_load", 32'(acc_load), 32'(e.load));
      check_eq("instr_done", 32'(instr_done), 32'(e.done));
      if (e.imm_chk) check_eq("imm", 32'(imm), 32'(e.imm));
    end
    if (acc_inc === 1'b1) inc_cnt++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Reset, release with run low, and park in IDLE at a falling edge.
  task automatic restart();
    run = 1'b0;
    zero = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp_q.delete();
  endtask

  task automatic run_jz(input logic z);
    logic [5:0] tgt;
    tgt = z ? 6'd5 : 6'd3;
    for (int i = 0; i < 64; i++) rom[i] = 8'hC0;
    rom[2] = 8'b0100_0101;  // JZ 5
    restart();
    zero = ~z;
    run = 1'b1;
    push(2'b00, 6'd0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    push_instr(6'd0, 1'b1, 1'b0, 8'h00);
    push_instr(6'd1, 1'b1, 1'b0, 8'h00);
    push_instr(6'd2, 1'b0, 1'b0, 8'h00);
    push_instr(tgt, 1'b1, 1'b0, 8'h00);
    steps(9);           // IDLE, two INCs, JZ fetch and decode
    zero = z;           // only the JZ EXECUTE cycle sees the tested value
    step();
    zero = ~z;
    steps(3);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 8'h00;
    rst_n = 1'b1;
    run = 1'b0;
    zero = 1'b0;
    #1 rst_n = 1'b0;
    @(negedge clk);
    check_eq("rst_state", 32'(state), 32'd0);
    check_eq("rst_address", 32'(address), 32'd0);
    check_eq("rst_acc_inc", 32'(acc_inc), 32'd0);
    check_eq("rst_acc_load", 32'(acc_load), 32'd0);
    check_eq("rst_instr_done", 32'(instr_done), 32'd0);
    check_eq("rst_imm", 32'(imm), 32'd0);

    // INC / JMP 0 loop: address 0,1,0,1..., acc_inc at cycles 3, 9, 15.
    rom[0] = 8'b1100_0000;
    rom[1] = 8'b1000_0000;
    restart();
    run = 1'b1;
    push(2'b00, 6'd0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) begin
      push_instr(6'(i % 2), (i % 2) == 0, 1'b0, 8'h00);
    end
    steps(16);

    // LDI 42: acc_load with imm=2A at cycle 3, no acc_inc.
    rom[0] = 8'b0010_1010;
    restart();
    run = 1'b1;
    push(2'b00, 6'd0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    push_instr(6'd0, 1'b0, 1'b1, 8'h2A);
    steps(4);

    // JZ taken and not taken.
    run_jz(1'b1);
    run_jz(1'b0);

    // All INC: PC walks 0..63 and wraps, 64 increments per lap.
    for (int i = 0; i < 64; i++) rom[i] = 8'hC0;
    restart();
    run = 1'b1;
    push(2'b00, 6'd0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 65; i++) push_instr(6'(i), 1'b1, 1'b0, 8'h00);
    inc_cnt = 0;
    steps(1 + 64 * 3);
    check_eq("lap_inc_count", 32'(inc_cnt), 32'd64);
    steps(3);

    // run dropped in DECODE: instruction completes, IDLE holds PC, resume from there.
    restart();
    run = 1'b1;
    push(2'b00, 6'd0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    push(2'b01, 6'd0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    steps(2);
    run = 1'b0;
    push(2'b10, 6'd1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    push(2'b11, 6'd1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    push(2'b00, 6'd1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    push(2'b00, 6'd1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    steps(4);
    run = 1'b1;
    push(2'b00, 6'd1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    push_instr(6'd1, 1'b1, 1'b0, 8'h00);
    steps(4);

    // Reset asserted during EXECUTE of INC aborts immediately.
    restart();
    run = 1'b1;
    push(2'b00, 6'd0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    push(2'b01, 6'd0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    push(2'b10, 6'd1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    steps(3);
    check_eq("exec_acc_inc", 32'(acc_inc), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("abort_acc_inc", 32'(acc_inc), 32'd0);
    check_eq("abort_state", 32'(state), 32'd0);
    check_eq("abort_address", 32'(address), 32'd0);
    check_eq("abort_instr_done", 32'(instr_done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    check_eq("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Fetch/decode/execute control unit for the Simple CPU. It owns the program counter and instruction register and drives the combinational instruction ROM's address. It decodes each 8-bit instruction into one-cycle control strobes for the accumulator datapath and sequences INC, LDI, JMP and JZ.

## Interface
- DATA_WIDTH, 8, instruction width; opcode = top 2 bits (DATA_WIDTH-ADDR_WIDTH must equal 2)
- ADDR_WIDTH, 6, ROM address / PC / operand width
- clk  in  1  system clock, rising-edge
- rst_n  in  1  asynchronous, active-low reset
- run  in  1  1 = execute program; 0 = stop at next instruction boundary
- instruction  in  DATA_WIDTH  ROM output for `address` (combinational ROM)
- zero  in  1  accumulator == 0 flag from datapath
- address  out  ADDR_WIDTH  ROM address, equals PC
- acc_inc  out  1  one-cycle strobe: accumulator += 1
- acc_load  out  1  one-cycle strobe: accumulator <= imm
- imm  out  DATA_WIDTH  zero-extended operand {2'b00, IR[5:0]}
- state  out  2  IDLE=00, FETCH=01, DECODE=10, EXECUTE=11
- instr_done  out  1  one-cycle pulse on the EXECUTE cycle

## Operation
- Opcodes (IR[7:6]): 11 INC; 10 JMP IR[5:0]; 01 JZ IR[5:0]; 00 LDI IR[5:0].
- IDLE: no strobes. Go to FETCH when run=1; otherwise stay.
- FETCH: address=PC. At the end of the cycle, IR <= instruction and PC <= PC+1 mod 64 (63 wraps to 0). Always go to DECODE.
- DECODE: register the decoded control into strobe flops. Go to EXECUTE.
- EXECUTE: exactly one of the following, then instr_done=1:
  - INC: acc_inc=1.
  - LDI: acc_load=1, imm valid.
  - JMP: PC <= IR[5:0].
  - JZ: PC <= IR[5:0] if zero=1 during EXECUTE, else PC unchanged.
- After EXECUTE: go to FETCH if run=1, else to IDLE.
- run is sampled only in IDLE and EXECUTE. Deasserting it mid-instruction completes the current instruction.
- zero is sampled only in EXECUTE. This lets an INC/LDI result settle before a following JZ.
- imm reflects IR continuously; it is meaningful only while acc_load=1.
- The jump target overrides the PC+1 computed in FETCH. JMP to the instruction's own address is a legal tight loop.

## Timing
- Reset (async assert, sync deassert expected): PC=0, IR=0, state=IDLE, address=0, acc_inc=0, acc_load=0, instr_done=0, imm=0.
- All outputs are registered or decoded from registers. There is no combinational path from instruction or zero to any output.
- Instruction latency: 3 cycles (FETCH, DECODE, EXECUTE) while run=1. Back-to-back instructions give one instr_done every 3 cycles.
- After reset release with run=1: cycle 0 IDLE, cycle 1 FETCH (address=0), cycle 3 first EXECUTE.
- A jump taken in cycle N EXECUTE presents address=target in the FETCH at N+1.
- Strobes are high for exactly one cycle, only in EXECUTE. They are never high in IDLE, FETCH or DECODE.
- rst_n asserted in any state aborts immediately. No strobe is issued and all registers return to reset values in the same cycle.

## Test plan
- ROM[0]=8'b11000000 (INC), ROM[1]=8'b10000000 (JMP 0), run=1 -> address sequence 0,1,0,1…; acc_inc pulses at cycles 3, 9, 15; instr_done every 3 cycles.
- ROM[0]=8'b00101010 (LDI 42) -> at cycle 3: acc_load=1 with imm=8'h2A for one cycle; acc_inc=0.
- JZ 5 at PC=2, zero=1 in EXECUTE -> next FETCH address=5. Repeat with zero=0 -> next FETCH address=3.
- ROM filled with INC -> PC counts 0..63 and wraps to 0; 64 acc_inc pulses per lap.
- run dropped during DECODE -> EXECUTE strobe still issued, then state=IDLE with PC held. Raising run again resumes FETCH at the held PC.
- rst_n pulsed low during EXECUTE of INC -> acc_inc=0 immediately, state=IDLE, address=0.
